// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 constants, dump FSM state type and icode values
// Purpose: common definitions for the register file and for upstream dst selection.
// Ports: none (package).
package y86_pkg;

   localparam logic [3:0] RNONE      = 4'hF;   // "no register" index
   localparam logic [3:0] RRSP       = 4'd4;   // %rsp
   localparam int         NREGS_Y86  = 15;
   localparam int         DATA_W_Y86 = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } dump_state_e;

   // Instruction codes, used upstream to pick dstE/dstM.
   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

endpackage

// File: rtl/regfile_dump_fsm.sv
// rtl/regfile_dump_fsm.sv - handshaked serial dump engine for the register file
// Purpose: on dump_req, streams registers 0..NREGS-1, one beat every two cycles.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   dump_req              start request (ignored while busy)
//   dump_ready            sink accepts current beat
//   load_data             post-write value of reg[dump_idx], sampled in LOAD
//   dump_valid/idx/data   current beat
//   dump_busy             engine not IDLE
module regfile_dump_fsm
   import y86_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int NREGS  = 15,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dump_req,
   input  logic              dump_ready,
   input  logic [DATA_W-1:0] load_data,
   output logic              dump_valid,
   output logic [ADDR_W-1:0] dump_idx,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_busy
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] idx_q,   idx_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q,  data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (dump_req) begin
               state_d = LOAD;
               idx_d   = '0;
            end
         end
         LOAD: begin
            // load_data already includes a write landing on this edge.
            data_d  = load_data;
            valid_d = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            // Data register is only reloaded in LOAD, so it holds while stalled.
            if (valid_q && dump_ready) begin
               valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = LOAD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dump_valid = valid_q;
   assign dump_idx   = idx_q;
   assign dump_data  = data_q;
   assign dump_busy  = (state_q != IDLE);

endmodule

// File: rtl/regfile_wb2p.sv
// rtl/regfile_wb2p.sv - Y86-64 register file, two write ports, two read ports, dump engine
// Purpose: storage with E/M writeback (M wins on conflict), combinational reads with
//   optional same-cycle forwarding, flat view of all registers, serial dump.
// Ports:
//   Clk, Rst_n             clock, async active-low reset
//   dstE/valE, dstM/valM   write ports; index >= NREGS (incl. RNONE) means no write
//   wb_en                  global write enable
//   srcA/srcB -> valA/valB read ports; 0 for index >= NREGS
//   regs_flat              stored registers, reg i at [i*DATA_W +: DATA_W]
//   dump_*                 dump engine request/handshake/beat/busy
module regfile_wb2p
   import y86_pkg::*;
#(
   parameter int DATA_W = DATA_W_Y86,
   parameter int NREGS  = NREGS_Y86,
   parameter int ADDR_W = 4,
   parameter int SP_IDX = int'(RRSP),
   parameter int BYPASS = 1
) (
   input  logic                    Clk,
   input  logic                    Rst_n,
   input  logic [ADDR_W-1:0]       dstE,
   input  logic [DATA_W-1:0]       valE,
   input  logic [ADDR_W-1:0]       dstM,
   input  logic [DATA_W-1:0]       valM,
   input  logic                    wb_en,
   input  logic [ADDR_W-1:0]       srcA,
   input  logic [ADDR_W-1:0]       srcB,
   output logic [DATA_W-1:0]       valA,
   output logic [DATA_W-1:0]       valB,
   output logic [NREGS*DATA_W-1:0] regs_flat,
   input  logic                    dump_req,
   output logic                    dump_valid,
   input  logic                    dump_ready,
   output logic [ADDR_W-1:0]       dump_idx,
   output logic [DATA_W-1:0]       dump_data,
   output logic                    dump_busy
);

   localparam logic [ADDR_W-1:0] NREGS_A = ADDR_W'(NREGS);

   // The all-ones index must stay unimplemented so it always reads as "no register".
   if (NREGS > (2**ADDR_W) - 1 || SP_IDX >= NREGS) begin : g_bad_params
      $error("regfile_wb2p: NREGS/SP_IDX out of range for ADDR_W");
   end

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [DATA_W-1:0] load_data;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      end
   end

   // Out-of-range indices never match an implemented register, so they drop out here.
   // M is applied after E so it wins when both target the same register.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
         if (wb_en && dstE == ADDR_W'(i)) regs_d[i] = valE;
         if (wb_en && dstM == ADDR_W'(i)) regs_d[i] = valM;
      end
   end

   always_comb begin
      valA = '0;
      valB = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (srcA == ADDR_W'(i)) valA = regs_q[i];
         if (srcB == ADDR_W'(i)) valB = regs_q[i];
      end
      if (BYPASS != 0 && wb_en) begin
         if (srcA < NREGS_A && srcA == dstE) valA = valE;
         if (srcA < NREGS_A && srcA == dstM) valA = valM;
         if (srcB < NREGS_A && srcB == dstE) valB = valE;
         if (srcB < NREGS_A && srcB == dstM) valB = valM;
      end
   end

   always_comb begin
      regs_flat = '0;
      for (int i = 0; i < NREGS; i++) regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
   end

   always_comb begin
      load_data = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (dump_idx == ADDR_W'(i)) load_data = regs_d[i];
      end
   end

   regfile_dump_fsm #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W)
   ) u_dump (
      .clk        (Clk),
      .rst_n      (Rst_n),
      .dump_req   (dump_req),
      .dump_ready (dump_ready),
      .load_data  (load_data),
      .dump_valid (dump_valid),
      .dump_idx   (dump_idx),
      .dump_data  (dump_data),
      .dump_busy  (dump_busy)
   );

endmodule

// File: tb/tb_regfile_wb2p.sv
// tb/tb_regfile_wb2p.sv - self-checking bench for regfile_wb2p (forwarding and non-forwarding)
module tb_regfile_wb2p;

   localparam int DW = 64;
   localparam int NR = 15;
   localparam int AW = 4;

   logic          Clk = 1'b0;
   logic          Rst_n;
   logic [AW-1:0] dstE, dstM, srcA, srcB;
   logic [DW-1:0] valE, valM;
   logic          wb_en, dump_req, dump_ready;

   logic [DW-1:0]    valA, valB, valA_nb, valB_nb;
   logic [NR*DW-1:0] regs_flat, regs_flat_nb;
   logic             dump_valid, dump_busy, dump_valid_nb, dump_busy_nb;
   logic [AW-1:0]    dump_idx, dump_idx_nb;
   logic [DW-1:0]    dump_data, dump_data_nb;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] model [NR];

   always #5 Clk = ~Clk;

   regfile_wb2p #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .SP_IDX(4), .BYPASS(1)) u_dut (
      .Clk(Clk), .Rst_n(Rst_n), .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
      .wb_en(wb_en), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
      .regs_flat(regs_flat), .dump_req(dump_req), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
      .dump_busy(dump_busy)
   );

   regfile_wb2p #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .SP_IDX(4), .BYPASS(0)) u_nb (
      .Clk(Clk), .Rst_n(Rst_n), .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
      .wb_en(wb_en), .srcA(srcA), .srcB(srcB), .valA(valA_nb), .valB(valB_nb),
      .regs_flat(regs_flat_nb), .dump_req(dump_req), .dump_valid(dump_valid_nb),
      .dump_ready(dump_ready), .dump_idx(dump_idx_nb), .dump_data(dump_data_nb),
      .dump_busy(dump_busy_nb)
   );

   // Reference read: out-of-range -> 0; forwarded M beats E beats stored.
   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] src, input bit byp);
      if (int'(src) >= NR) return '0;
      if (byp && wb_en && src == dstM) return valM;
      if (byp && wb_en && src == dstE) return valE;
      return model[int'(src)];
   endfunction

   function automatic logic [NR*DW-1:0] model_flat();
      logic [NR*DW-1:0] f;
      for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
      return f;
   endfunction

   // Applies the writes the next clock edge will perform (E then M).
   task automatic model_commit();
      if (wb_en) begin
         if (int'(dstE) < NR) model[int'(dstE)] = valE;
         if (int'(dstM) < NR) model[int'(dstM)] = valM;
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NR; i++) model[i] = '0;
   endtask

   task automatic tick();
      model_commit();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb_en = 1'b0; dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
   endtask

   task automatic check_flat(input string name);
      checks++;
      if (regs_flat !== model_flat() || regs_flat_nb !== model_flat()) begin
         errors++;
         $display("FAIL %s: regs_flat got %h expected %h", name, regs_flat, model_flat());
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (regs_flat !== '0 || dump_valid !== 1'b0 || dump_idx !== '0 ||
          dump_data !== '0 || dump_busy !== 1'b0 || valA !== '0) begin
         errors++;
         $display("FAIL reset_state: flat=%h valid=%b idx=%h data=%h busy=%b valA=%h",
                  regs_flat, dump_valid, dump_idx, dump_data, dump_busy, valA);
      end
      Rst_n = 1'b1;
      @(posedge Clk); #1;
      dstE = 4'd1; valE = 64'h1234; dstM = 4'd2; valM = 64'h5678; wb_en = 1'b1;
      tick();
      idle_inputs();
      check_flat("pre_reset_write");
      #3;
      Rst_n = 1'b0;
      #1;
      model_clear();
      checks++;
      if (regs_flat !== '0 || regs_flat_nb !== '0 || dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: flat=%h valid=%b busy=%b expected all 0",
                  regs_flat, dump_valid, dump_busy);
      end
      @(negedge Clk);
      Rst_n = 1'b1;
      @(posedge Clk); #1;
   endtask

   task automatic test_dual_write();
      dstE = 4'd3; valE = 64'h11; dstM = 4'd5; valM = 64'h22; wb_en = 1'b1;
      tick();
      idle_inputs();
      checks++;
      if (regs_flat[3*DW +: DW] !== 64'h11 || regs_flat[5*DW +: DW] !== 64'h22) begin
         errors++;
         $display("FAIL dual_write: reg3=%h reg5=%h expected 11 22",
                  regs_flat[3*DW +: DW], regs_flat[5*DW +: DW]);
      end
      check_flat("dual_write_flat");
   endtask

   task automatic test_conflict();
      dstE = 4'd4; valE = 64'h55; wb_en = 1'b1;
      tick();
      dstE = 4'd4; valE = 64'hAA; dstM = 4'd4; valM = 64'hBB; wb_en = 1'b1; srcA = 4'd4;
      #1;
      checks++;
      if (valA !== 64'hBB) begin
         errors++;
         $display("FAIL conflict_bypass: valA got %h expected bb", valA);
      end
      checks++;
      if (valA_nb !== 64'h55) begin
         errors++;
         $display("FAIL conflict_nobypass: valA got %h expected 55", valA_nb);
      end
      tick();
      idle_inputs();
      checks++;
      if (regs_flat[4*DW +: DW] !== 64'hBB || regs_flat_nb[4*DW +: DW] !== 64'hBB) begin
         errors++;
         $display("FAIL conflict_write: reg4 got %h expected bb", regs_flat[4*DW +: DW]);
      end
   endtask

   task automatic test_rnone_disable();
      dstE = 4'hF; valE = 64'h77; dstM = 4'd7; valM = 64'd9; wb_en = 1'b1;
      tick();
      checks++;
      if (regs_flat[7*DW +: DW] !== 64'd9) begin
         errors++;
         $display("FAIL rnone_write: reg7 got %h expected 9", regs_flat[7*DW +: DW]);
      end
      check_flat("rnone_flat");
      wb_en = 1'b0; dstE = 4'd2; valE = 64'hDEAD; dstM = 4'd7; valM = 64'hBEEF; srcA = 4'd2;
      #1;
      checks++;
      if (valA !== model[2]) begin
         errors++;
         $display("FAIL disabled_no_forward: valA got %h expected %h", valA, model[2]);
      end
      tick();
      check_flat("wb_disabled");
      wb_en = 1'b1; dstE = 4'd1; dstM = 4'hF; valM = 64'h123; srcB = 4'hF;
      #1;
      checks++;
      if (valB !== '0 || valB_nb !== '0) begin
         errors++;
         $display("FAIL rnone_read: valB got %h/%h expected 0", valB, valB_nb);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         dstE  = 4'($urandom_range(0, 15));
         dstM  = 4'($urandom_range(0, 15));
         valE  = {$urandom, $urandom};
         valM  = {$urandom, $urandom};
         wb_en = ($urandom_range(0, 3) != 0);
         srcA  = ($urandom_range(0, 2) == 0) ? dstM : 4'($urandom_range(0, 15));
         srcB  = ($urandom_range(0, 2) == 0) ? dstE : 4'($urandom_range(0, 15));
         #1;
         checks++;
         if (valA !== model_read(srcA, 1) || valB !== model_read(srcB, 1)) begin
            errors++;
            $display("FAIL rand_read_bypass: valA=%h valB=%h expected %h %h",
                     valA, valB, model_read(srcA, 1), model_read(srcB, 1));
         end
         checks++;
         if (valA_nb !== model_read(srcA, 0) || valB_nb !== model_read(srcB, 0)) begin
            errors++;
            $display("FAIL rand_read_stored: valA=%h valB=%h expected %h %h",
                     valA_nb, valB_nb, model_read(srcA, 0), model_read(srcB, 0));
         end
         tick();
         check_flat("rand_flat");
      end
      idle_inputs();
   endtask

   // Runs one dump and checks every accepted beat against the register contents at start.
   // With toggle set, ready is random and the displayed register is rewritten while stalled.
   task automatic run_dump(input bit toggle, input bit extra_req, input int exp_cycles);
      logic [DW-1:0] snap [NR];
      int            cycles, beats;
      bit            held;
      logic [AW-1:0] h_idx;
      logic [DW-1:0] h_data;
      for (int i = 0; i < NR; i++) snap[i] = model[i];
      idle_inputs();
      dump_ready = 1'b1;
      dump_req   = 1'b1;
      @(posedge Clk); #1;
      dump_req = 1'b0;
      cycles = 0; beats = 0; held = 0;
      h_idx = '0; h_data = '0;
      while (1) begin
         if (held) begin
            checks++;
            if (dump_valid !== 1'b1 || dump_idx !== h_idx || dump_data !== h_data) begin
               errors++;
               $display("FAIL dump_stall_hold: valid=%b idx=%h data=%h expected 1 %h %h",
                        dump_valid, dump_idx, dump_data, h_idx, h_data);
            end
         end
         if (!dump_busy) break;
         if (cycles >= 400) begin
            checks++; errors++;
            $display("FAIL dump_timeout: busy still %b after %0d cycles", dump_busy, cycles);
            break;
         end
         dump_ready = toggle ? ($urandom_range(0, 1) == 1) : 1'b1;
         dump_req   = extra_req && (cycles == 10);
         idle_inputs();
         held = 0;
         if (dump_valid && dump_ready) begin
            checks++;
            if (beats >= NR || dump_idx !== AW'(beats) || dump_data !== snap[beats % NR]) begin
               errors++;
               $display("FAIL dump_beat: idx=%h data=%h expected idx %0d data %h",
                        dump_idx, dump_data, beats, snap[beats % NR]);
            end
            beats++;
         end else if (dump_valid) begin
            held   = 1;
            h_idx  = dump_idx;
            h_data = dump_data;
            if (toggle) begin
               wb_en = 1'b1; dstE = dump_idx; valE = {$urandom, $urandom};
            end
         end
         tick();
         cycles++;
      end
      dump_req = 1'b0;
      idle_inputs();
      checks++;
      if (beats != NR) begin
         errors++;
         $display("FAIL dump_beat_count: got %0d expected %0d", beats, NR);
      end
      if (exp_cycles > 0) begin
         checks++;
         if (cycles != exp_cycles) begin
            errors++;
            $display("FAIL dump_cycles: got %0d expected %0d", cycles, exp_cycles);
         end
      end
      @(posedge Clk); #1;
      checks++;
      if (dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
         errors++;
         $display("FAIL dump_idle_after: busy=%b valid=%b expected 0 0", dump_busy, dump_valid);
      end
   endtask

   task automatic test_dump();
      for (int i = 0; i < NR; i += 2) begin
         wb_en = 1'b1;
         dstE = 4'(i);     valE = 64'(i * 64'h101);
         dstM = (i + 1 < NR) ? 4'(i + 1) : 4'hF;
         valM = 64'((i + 1) * 64'h101);
         tick();
      end
      idle_inputs();
      check_flat("dump_preload");
      run_dump(1'b0, 1'b1, 2 * NR);
      run_dump(1'b1, 1'b0, 0);
      check_flat("dump_writes_landed");
   endtask

   task automatic test_reset_during_dump();
      bit found;
      found = 0;
      dump_ready = 1'b1;
      dump_req   = 1'b1;
      @(posedge Clk); #1;
      dump_req = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         @(posedge Clk); #1;
         if (dump_valid && dump_idx == 4'd6) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL dump_reach_idx6: valid=%b idx=%h", dump_valid, dump_idx);
      end
      #3;
      Rst_n = 1'b0;
      #1;
      model_clear();
      checks++;
      if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_idx !== '0 ||
          dump_data !== '0 || regs_flat !== '0) begin
         errors++;
         $display("FAIL reset_mid_dump: valid=%b busy=%b idx=%h data=%h expected all 0",
                  dump_valid, dump_busy, dump_idx, dump_data);
      end
      @(negedge Clk);
      Rst_n = 1'b1;
      @(posedge Clk); #1;
      checks++;
      if (dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
         errors++;
         $display("FAIL no_beats_after_reset: busy=%b valid=%b", dump_busy, dump_valid);
      end
      run_dump(1'b0, 1'b0, 2 * NR);
   endtask

   initial begin
      Rst_n = 1'b0;
      srcA = '0; srcB = '0;
      dump_req = 1'b0; dump_ready = 1'b0;
      idle_inputs();
      model_clear();
      test_reset();
      test_dual_write();
      test_conflict();
      test_rnone_disable();
      test_random();
      test_dump();
      test_reset_during_dump();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
